matmul_mem_sequencer: RTL and testbench
=======================================

Name: matmul_mem_sequencer

Overview:
- Top-level controller for the 32x32 fp16 matmul wrapper and its A/B/C single-port RAMs.
- Accepts a host row stream and writes MAT_SIZE rows into A, then MAT_SIZE rows into B, applying the wrapper's address-register latency.
- Holds start_mat_mul until done_mat_mul, enabling C writes throughout, then reads C back as an output row stream.
- Replaces hand-sequenced host stimulus with one job-level start/busy/done handshake.

Parameters:
- MAT_SIZE, 32, rows per matrix; also the number of C rows read back.
- AWIDTH, 7, RAM address width.
- ROW_W, 512, row width (MAT_SIZE x 16-bit fp16).
- WR_LAT, 2, cycles from addr_pi to the RAM address register; we_a/we_b/data_pi are delayed by this amount.
- RD_LAT, 4, cycles from addr_pi issue to a valid data_from_out_mat.

Ports:
- clk  in  1  single clock; mem clock and compute clock are tied to it.
- reset  in  1  synchronous, active-high.
- job_start  in  1  one-cycle pulse that begins a job; ignored unless in IDLE.
- job_busy  out  1  high from job accept through final output row.
- job_done  out  1  one-cycle pulse after the last C row is delivered.
- in_valid  in  1  host row valid.
- in_ready  out  1  sequencer accepts a row this cycle.
- in_data  in  ROW_W  host row (A rows first, then B rows).
- enable_writing_to_mem  out  1  to wrapper.
- enable_reading_from_mem  out  1  to wrapper.
- addr_pi  out  AWIDTH  to wrapper.
- data_pi  out  ROW_W  to wrapper; in_data delayed WR_LAT cycles.
- we_a, we_b, we_c  out  1 each  to wrapper.
- start_mat_mul  out  1  to wrapper.
- done_mat_mul  in  1  from wrapper.
- data_from_out_mat  in  ROW_W  from wrapper.
- out_valid  out  1  C row valid; there is no backpressure.
- out_data  out  ROW_W  C row.
- out_row  out  AWIDTH  index of the current out_data row.

Behaviour:
- Reset: every output is 0 and the FSM enters IDLE. The write and read delay pipes are cleared. A reset mid-job aborts with no job_done.
- FSM states: IDLE, LOAD_A, LOAD_B, WR_FLUSH, COMPUTE, RD_ISSUE, RD_DRAIN.
- IDLE: on job_start, go to LOAD_A, clear the row counter, set job_busy.
- LOAD_A / LOAD_B:
  - in_ready=1 and enable_writing_to_mem=1.
  - On each accept (in_valid & in_ready), addr_pi = row counter; the counter increments.
  - in_data and a write tag (A or B) enter a WR_LAT-deep pipe. we_a or we_b is asserted WR_LAT cycles after the accept, aligned with data_pi.
  - No accept means no write and addr_pi holds its value.
  - After accept of row MAT_SIZE-1: counter returns to 0 and LOAD_A goes to LOAD_B; LOAD_B goes to WR_FLUSH.
- WR_FLUSH:
  - in_ready=0; enable_writing_to_mem stays 1 for WR_LAT cycles so in-flight writes land.
  - Then go to COMPUTE with addr_pi=0.
- COMPUTE:
  - start_mat_mul=1 and we_c=1 every cycle.
  - When done_mat_mul is sampled high, drop both next cycle and go to RD_ISSUE.
  - If done_mat_mul is already high on entry (stale), ignore it for the first cycle.
- RD_ISSUE:
  - enable_reading_from_mem=1; addr_pi = 0..MAT_SIZE-1, one per cycle.
  - The row index enters an RD_LAT-deep valid/index pipe.
  - After MAT_SIZE-1 is issued, go to RD_DRAIN.
- RD_DRAIN:
  - enable_reading_from_mem stays 1 until the pipe empties.
  - out_valid/out_row are the pipe output; out_data = data_from_out_mat, taken combinationally.
  - When the pipe is empty: pulse job_done, drop job_busy, go to IDLE.
- Boundaries:
  - job_start while busy is ignored.
  - in_valid outside LOAD_A/LOAD_B is ignored.
  - The row counter never wraps past MAT_SIZE-1.
  - done_mat_mul outside COMPUTE is ignored.
  - job_start in the same cycle job_done is pulsed is ignored; the FSM is not yet in IDLE.

Optional Feature:
- MATMUL_SEQ_PERF_CNT_EN:
  - Adds output compute_cycles (32 bits). It counts COMPUTE cycles of the current job, clears on job accept, and holds after done.
  - It saturates at all-ones.
  - Without the macro, the port and counter do not exist.

Test Plan:
- Reset mid-LOAD_B (row 10):
  - All outputs 0 the next cycle and FSM in IDLE.
  - A new job_start then loads A from row 0.
- Full job, in_valid always high:
  - Accept rows 0..31 to A, then 0..31 to B.
  - we_a is high exactly 32 cycles, each 2 cycles after the matching addr_pi.
  - data_pi matches in_data delayed 2 cycles.
- Backpressure gaps: in_valid deasserted every third cycle during LOAD_A.
  - No write occurs for gap cycles.
  - Addresses remain contiguous 0..31.
- Compute handshake: model raises done_mat_mul 40 cycles after start.
  - start_mat_mul and we_c are high exactly 40 cycles.
  - A done_mat_mul pulse injected in LOAD_A is ignored.
- Readback:
  - Model returns row index in data after 4 cycles.
  - out_valid for 32 consecutive cycles with out_row 0..31 equal to the data.
  - job_done pulses one cycle after row 31; a job_start during busy is ignored.
- Perf counter (with MATMUL_SEQ_PERF_CNT_EN):
  - compute_cycles reads 40 after the job above.
  - It resets to 0 on the next job accept.

Source files
------------

// File: rtl/matmul_mem_sequencer_if.sv
`default_nettype none
//==============================================================================
// Module   : matmul_mem_sequencer_if
// Desc     : Host row stream, job handshake and wrapper bus of the sequencer.
// Revision : 1.0
//==============================================================================
interface matmul_mem_sequencer_if #(
  parameter int AWIDTH = 7,
  parameter int ROW_W  = 512
);
  logic              job_start;
  logic              job_busy;
  logic              job_done;
  logic              in_valid;
  logic              in_ready;
  logic [ROW_W-1:0]  in_data;
  logic              enable_writing_to_mem;
  logic              enable_reading_from_mem;
  logic [AWIDTH-1:0] addr_pi;
  logic [ROW_W-1:0]  data_pi;
  logic              we_a;
  logic              we_b;
  logic              we_c;
  logic              start_mat_mul;
  logic              done_mat_mul;
  logic [ROW_W-1:0]  data_from_out_mat;
  logic              out_valid;
  logic [ROW_W-1:0]  out_data;
  logic [AWIDTH-1:0] out_row;

  // Sequencer side
  modport master (
    input  job_start, in_valid, in_data, done_mat_mul, data_from_out_mat,
    output job_busy, job_done, in_ready, enable_writing_to_mem,
           enable_reading_from_mem, addr_pi, data_pi, we_a, we_b, we_c,
           start_mat_mul, out_valid, out_data, out_row
  );

  // Host / wrapper side
  modport slave (
    output job_start, in_valid, in_data, done_mat_mul, data_from_out_mat,
    input  job_busy, job_done, in_ready, enable_writing_to_mem,
           enable_reading_from_mem, addr_pi, data_pi, we_a, we_b, we_c,
           start_mat_mul, out_valid, out_data, out_row
  );
endinterface
`default_nettype wire

// File: rtl/matmul_mem_sequencer.sv
`default_nettype none
//==============================================================================
// Module   : matmul_mem_sequencer
// Desc     : Loads A/B rows, runs the matmul, streams C back under one job
//            handshake. Macro MATMUL_SEQ_PERF_CNT_EN adds compute_cycles.
// Revision : 1.0
//==============================================================================
module matmul_mem_sequencer #(
  parameter int MAT_SIZE = 32,
  parameter int AWIDTH   = 7,
  parameter int ROW_W    = 512,
  parameter int WR_LAT   = 2,
  parameter int RD_LAT   = 4
) (
  input wire clk,
  input wire reset,
  matmul_mem_sequencer_if.master bus
`ifdef MATMUL_SEQ_PERF_CNT_EN
  ,
  output logic [31:0] compute_cycles
`endif
);

  localparam logic [2:0] c_ST_IDLE     = 3'd0;
  localparam logic [2:0] c_ST_LOAD_A   = 3'd1;
  localparam logic [2:0] c_ST_LOAD_B   = 3'd2;
  localparam logic [2:0] c_ST_WR_FLUSH = 3'd3;
  localparam logic [2:0] c_ST_COMPUTE  = 3'd4;
  localparam logic [2:0] c_ST_RD_ISSUE = 3'd5;
  localparam logic [2:0] c_ST_RD_DRAIN = 3'd6;

  localparam logic [AWIDTH-1:0] c_LAST_ROW   = AWIDTH'(MAT_SIZE - 1);
  localparam logic [AWIDTH-1:0] c_FLUSH_LAST = AWIDTH'(WR_LAT - 1);

  logic [2:0]        r_state;
  logic [2:0]        w_next_state;
  logic [AWIDTH-1:0] r_row_cnt;
  logic [AWIDTH-1:0] r_addr;
  logic              r_cmp_armed;

  logic [ROW_W-1:0]  r_wr_data [WR_LAT];
  logic [WR_LAT-1:0] r_wr_a;
  logic [WR_LAT-1:0] r_wr_b;
  logic [RD_LAT-1:0] r_rd_v;
  logic [AWIDTH-1:0] r_rd_idx [RD_LAT];

  logic w_load;
  logic w_accept;
  logic w_last_row;
  logic w_flush_done;
  logic w_rd_empty;
  logic w_job_accept;

  assign w_load       = (r_state == c_ST_LOAD_A) || (r_state == c_ST_LOAD_B);
  assign w_accept     = w_load && bus.in_valid;
  assign w_last_row   = (r_row_cnt == c_LAST_ROW);
  assign w_flush_done = (r_row_cnt == c_FLUSH_LAST);
  assign w_rd_empty   = ~|r_rd_v;
  assign w_job_accept = (r_state == c_ST_IDLE) && bus.job_start;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_ST_IDLE:     if (bus.job_start)             w_next_state = c_ST_LOAD_A;
      c_ST_LOAD_A:   if (w_accept && w_last_row)    w_next_state = c_ST_LOAD_B;
      c_ST_LOAD_B:   if (w_accept && w_last_row)    w_next_state = c_ST_WR_FLUSH;
      c_ST_WR_FLUSH: if (w_flush_done)              w_next_state = c_ST_COMPUTE;
      // A done left high from a previous run is not trusted on the entry cycle
      c_ST_COMPUTE:  if (bus.done_mat_mul && r_cmp_armed) w_next_state = c_ST_RD_ISSUE;
      c_ST_RD_ISSUE: if (w_last_row)                w_next_state = c_ST_RD_DRAIN;
      c_ST_RD_DRAIN: if (w_rd_empty)                w_next_state = c_ST_IDLE;
      default:                                      w_next_state = c_ST_IDLE;
    endcase
  end

  always_comb begin
    bus.job_busy                = (r_state != c_ST_IDLE);
    bus.job_done                = (r_state == c_ST_RD_DRAIN) && w_rd_empty;
    bus.in_ready                = w_load;
    bus.enable_writing_to_mem   = w_load || (r_state == c_ST_WR_FLUSH);
    bus.enable_reading_from_mem = (r_state == c_ST_RD_ISSUE) || (r_state == c_ST_RD_DRAIN);
    bus.start_mat_mul           = (r_state == c_ST_COMPUTE);
    bus.we_c                    = (r_state == c_ST_COMPUTE);
    // The accept cycle presents the new row address; otherwise the last one holds
    bus.addr_pi   = (w_accept || (r_state == c_ST_RD_ISSUE)) ? r_row_cnt : r_addr;
    bus.data_pi   = r_wr_data[WR_LAT-1];
    bus.we_a      = r_wr_a[WR_LAT-1];
    bus.we_b      = r_wr_b[WR_LAT-1];
    bus.out_valid = r_rd_v[RD_LAT-1];
    bus.out_row   = r_rd_idx[RD_LAT-1];
    bus.out_data  = r_rd_v[RD_LAT-1] ? bus.data_from_out_mat : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_row_cnt   <= '0;
      r_addr      <= '0;
      r_cmp_armed <= 1'b0;
    end else begin
      r_cmp_armed <= (r_state == c_ST_COMPUTE);
      case (r_state)
        c_ST_IDLE: r_row_cnt <= '0;
        c_ST_LOAD_A, c_ST_LOAD_B: begin
          if (w_accept) begin
            r_addr    <= r_row_cnt;
            r_row_cnt <= w_last_row ? '0 : r_row_cnt + 1'b1;
          end
        end
        // The row counter doubles as the flush timer
        c_ST_WR_FLUSH: begin
          if (w_flush_done) begin
            r_row_cnt <= '0;
            r_addr    <= '0;
          end else begin
            r_row_cnt <= r_row_cnt + 1'b1;
          end
        end
        c_ST_RD_ISSUE: begin
          r_addr    <= r_row_cnt;
          r_row_cnt <= w_last_row ? '0 : r_row_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_a <= '0;
      r_wr_b <= '0;
      r_rd_v <= '0;
      for (int i = 0; i < WR_LAT; i++) r_wr_data[i] <= '0;
      for (int i = 0; i < RD_LAT; i++) r_rd_idx[i]  <= '0;
    end else begin
      r_wr_a[0]    <= w_accept && (r_state == c_ST_LOAD_A);
      r_wr_b[0]    <= w_accept && (r_state == c_ST_LOAD_B);
      r_wr_data[0] <= w_accept ? bus.in_data : '0;
      for (int i = 1; i < WR_LAT; i++) begin
        r_wr_a[i]    <= r_wr_a[i-1];
        r_wr_b[i]    <= r_wr_b[i-1];
        r_wr_data[i] <= r_wr_data[i-1];
      end
      r_rd_v[0]   <= (r_state == c_ST_RD_ISSUE);
      r_rd_idx[0] <= r_row_cnt;
      for (int i = 1; i < RD_LAT; i++) begin
        r_rd_v[i]   <= r_rd_v[i-1];
        r_rd_idx[i] <= r_rd_idx[i-1];
      end
    end
  end

`ifdef MATMUL_SEQ_PERF_CNT_EN
  logic [31:0] r_compute_cycles;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_compute_cycles <= '0;
    end else if (w_job_accept) begin
      r_compute_cycles <= '0;
    end else if ((r_state == c_ST_COMPUTE) && (r_compute_cycles != '1)) begin
      r_compute_cycles <= r_compute_cycles + 32'd1;
    end
  end

  assign compute_cycles = r_compute_cycles;
`else
  logic w_unused_job_accept;
  assign w_unused_job_accept = w_job_accept;
`endif

endmodule
`default_nettype wire

// File: tb/tb_matmul_mem_sequencer.sv
`default_nettype none
//==============================================================================
// Module   : tb_matmul_mem_sequencer
// Desc     : Scoreboard bench: driver queues expected writes/rows, monitor pops.
// Revision : 1.0
//==============================================================================
module tb_matmul_mem_sequencer;
  localparam int MAT_SIZE   = 32;
  localparam int AWIDTH     = 7;
  localparam int ROW_W      = 512;
  localparam int WR_LAT     = 2;
  localparam int RD_LAT     = 4;
  localparam int CMP_CYCLES = 40;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  matmul_mem_sequencer_if #(.AWIDTH(AWIDTH), .ROW_W(ROW_W)) bus ();
`ifdef MATMUL_SEQ_PERF_CNT_EN
  logic [31:0] compute_cycles;
`endif

  matmul_mem_sequencer #(
    .MAT_SIZE(MAT_SIZE), .AWIDTH(AWIDTH), .ROW_W(ROW_W),
    .WR_LAT(WR_LAT), .RD_LAT(RD_LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef MATMUL_SEQ_PERF_CNT_EN
    ,
    .compute_cycles (compute_cycles)
`endif
  );

  typedef struct {
    bit               is_b;
    int               row;
    logic [ROW_W-1:0] data;
  } wr_t;

  wr_t exp_wr[$];
  int  exp_out[$];
  int  exp_done[$];
  int  exp_cmp[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Wrapper model: done after CMP_CYCLES of start, C row data = row index
  logic              inject_done = 1'b0;
  logic [7:0]        sc = 8'd0;
  logic [AWIDTH-1:0] rm [RD_LAT];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    sc  <= bus.start_mat_mul ? sc + 8'd1 : 8'd0;
    rm[0] <= bus.addr_pi;
    for (int i = 1; i < RD_LAT; i++) rm[i] <= rm[i-1];
  end

  assign bus.done_mat_mul      = inject_done | (bus.start_mat_mul && (sc == 8'(CMP_CYCLES - 1)));
  assign bus.data_from_out_mat = ROW_W'(rm[RD_LAT-1]);

  task automatic chk(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input int act, input int exp);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [ROW_W-1:0] mkrow(input int job, input bit is_b, input int row);
    logic [ROW_W-1:0] r;
    logic [31:0]      w;
    w = {8'(job), 7'h0, is_b, 16'(row)};
    for (int k = 0; k < ROW_W / 32; k++) r[k*32 +: 32] = w ^ 32'(k << 20);
    return r;
  endfunction

  // ---------------- monitor ----------------
  logic [AWIDTH-1:0] ah [WR_LAT];
  int  st_cnt = 0;
  int  wec_bad = 0;
  bit  prev_start = 1'b0;
  int  last_out_cyc = -10;
  int  last_out_row = -1;

  always @(negedge clk) begin
    wr_t e;
    int  r;
    if (!reset) begin
      if (bus.we_a || bus.we_b) begin
        if (exp_wr.size() == 0) begin
          fail_now("unexpected_write", int'(bus.addr_pi), -1);
        end else begin
          e = exp_wr.pop_front();
          chk("we_a", ROW_W'(bus.we_a), ROW_W'(!e.is_b));
          chk("we_b", ROW_W'(bus.we_b), ROW_W'(e.is_b));
          chk("wr_addr", ROW_W'(ah[WR_LAT-1]), ROW_W'(e.row));
          chk("data_pi", bus.data_pi, e.data);
          chk("wr_enable", ROW_W'(bus.enable_writing_to_mem), ROW_W'(1));
        end
      end
      for (int i = WR_LAT - 1; i > 0; i--) ah[i] = ah[i-1];
      ah[0] = bus.addr_pi;

      if (bus.start_mat_mul) st_cnt++;
      if (bus.we_c !== bus.start_mat_mul) wec_bad++;
      if (prev_start && !bus.start_mat_mul) begin
        if (exp_cmp.size() == 0) begin
          fail_now("unexpected_compute", st_cnt, 0);
        end else begin
          chk("start_cycles", ROW_W'(st_cnt), ROW_W'(exp_cmp.pop_front()));
          chk("we_c_tracks_start", ROW_W'(wec_bad), ROW_W'(0));
        end
        st_cnt  = 0;
        wec_bad = 0;
      end
      prev_start = bus.start_mat_mul;

      if (bus.out_valid) begin
        if (exp_out.size() == 0) begin
          fail_now("unexpected_out_row", int'(bus.out_row), -1);
        end else begin
          r = exp_out.pop_front();
          chk("out_row", ROW_W'(bus.out_row), ROW_W'(r));
          chk("out_data", bus.out_data, ROW_W'(r));
          chk("rd_enable", ROW_W'(bus.enable_reading_from_mem), ROW_W'(1));
          if (r != 0) chk("out_consecutive", ROW_W'(cyc), ROW_W'(last_out_cyc + 1));
        end
        last_out_cyc = cyc;
        last_out_row = int'(bus.out_row);
      end

      if (bus.job_done) begin
        if (exp_done.size() == 0) begin
          fail_now("unexpected_job_done", cyc, -1);
        end else begin
          void'(exp_done.pop_front());
          chk("done_after_row", ROW_W'(last_out_row), ROW_W'(MAT_SIZE - 1));
          chk("done_cycle", ROW_W'(cyc), ROW_W'(last_out_cyc + 1));
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic chk_idle(input string tag);
    chk({tag, "_ctrl"}, ROW_W'({bus.job_busy, bus.job_done, bus.in_ready,
        bus.enable_writing_to_mem, bus.enable_reading_from_mem, bus.we_a, bus.we_b,
        bus.we_c, bus.start_mat_mul, bus.out_valid}), ROW_W'(0));
    chk({tag, "_addr_pi"}, ROW_W'(bus.addr_pi), ROW_W'(0));
    chk({tag, "_data_pi"}, bus.data_pi, ROW_W'(0));
    chk({tag, "_out_data"}, bus.out_data, ROW_W'(0));
    chk({tag, "_out_row"}, ROW_W'(bus.out_row), ROW_W'(0));
  endtask

  task automatic start_job(input bit expect_finish);
    if (expect_finish) begin
      exp_cmp.push_back(CMP_CYCLES);
      for (int i = 0; i < MAT_SIZE; i++) exp_out.push_back(i);
      exp_done.push_back(1);
    end
    bus.job_start = 1'b1;
    @(posedge clk); #1;
    bus.job_start = 1'b0;
  endtask

  task automatic send_rows(input int job, input bit is_b, input bit gaps, input bit inject, input int count);
    int n = 0;
    int k = 0;
    while (n < count && k < 200) begin
      bus.in_valid = !(gaps && (k % 3 == 2));
      bus.in_data  = mkrow(job, is_b, n);
      inject_done  = inject && (n == 5);
      if (bus.in_valid && bus.in_ready) begin
        exp_wr.push_back('{is_b, n, mkrow(job, is_b, n)});
        n++;
      end
      @(posedge clk); #1;
      k++;
    end
    bus.in_valid = 1'b0;
    inject_done  = 1'b0;
    if (n != count) fail_now("send_rows_timeout", n, count);
  endtask

  task automatic wait_done();
    int  k = 0;
    bit  poked = 1'b0;
    while (!bus.job_done && k < 600) begin
      bus.job_start = bus.out_valid && !poked;
      if (bus.job_start) begin
        poked = 1'b1;
        chk("busy_during_readback", ROW_W'(bus.job_busy), ROW_W'(1));
      end
      @(posedge clk); #1;
      k++;
    end
    bus.job_start = 1'b0;
    if (!bus.job_done) begin
      fail_now("job_done_timeout", k, 600);
    end else begin
      bus.job_start = 1'b1;
      @(posedge clk); #1;
      bus.job_start = 1'b0;
      chk("start_at_done_ignored", ROW_W'(bus.job_busy), ROW_W'(0));
      chk("idle_in_ready", ROW_W'(bus.in_ready), ROW_W'(0));
      chk("write_queue_drained", ROW_W'(exp_wr.size()), ROW_W'(0));
    end
  endtask

  initial begin
    bus.job_start = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk_idle("reset");

    // Job 0: aborted by reset in the middle of LOAD_B
    start_job(1'b0);
    send_rows(0, 1'b0, 1'b0, 1'b0, MAT_SIZE);
    send_rows(0, 1'b1, 1'b0, 1'b0, 10);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_wr.delete();
    chk_idle("mid_b_reset");

    // Job 1: continuous rows, stray done pulse during LOAD_A
    start_job(1'b1);
    send_rows(1, 1'b0, 1'b0, 1'b1, MAT_SIZE);
    send_rows(1, 1'b1, 1'b0, 1'b0, MAT_SIZE);
    wait_done();
`ifdef MATMUL_SEQ_PERF_CNT_EN
    chk("compute_cycles_after_job", ROW_W'(compute_cycles), ROW_W'(CMP_CYCLES));
`endif

    // Job 2: every third LOAD_A cycle has no valid row
    start_job(1'b1);
`ifdef MATMUL_SEQ_PERF_CNT_EN
    chk("compute_cycles_cleared", ROW_W'(compute_cycles), ROW_W'(0));
`endif
    send_rows(2, 1'b0, 1'b1, 1'b0, MAT_SIZE);
    send_rows(2, 1'b1, 1'b0, 1'b0, MAT_SIZE);
    wait_done();

    repeat (5) @(posedge clk);
    #1;
    chk("pending_writes", ROW_W'(exp_wr.size()), ROW_W'(0));
    chk("pending_rows", ROW_W'(exp_out.size()), ROW_W'(0));
    chk("pending_done", ROW_W'(exp_done.size()), ROW_W'(0));
    chk("pending_compute", ROW_W'(exp_cmp.size()), ROW_W'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1);
  end
endmodule
`default_nettype wire
